// File: rtl/mod_arbiter.sv
// Round-robin arbiter/sequencer sharing one vector-modulus engine between N_REQ requesters.
// Optional watchdog on the engine run is enabled by defining MOD_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no job; picks the next requester round-robin and latches its operands
// START | one-cycle grant to the winner and start pulse to the engine
// WAIT  | engine running on held operands; waiting for eng_ok (or watchdog)
// RESP  | one-cycle done pulse with q_out/done_id
module mod_arbiter #(
    parameter int N_REQ = 4,
    parameter int W_IN  = 14,
    parameter int W_OUT = 24,
    parameter int ID_W  = 2,
    parameter int TMO   = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*W_IN-1:0]   a_bus,
    input  logic [N_REQ*W_IN-1:0]   b_bus,
    output logic [N_REQ-1:0]        gnt,
    output logic                    done,
    output logic [ID_W-1:0]         done_id,
    output logic [W_OUT-1:0]        q_out,
    output logic                    busy,
    output logic                    err,
    output logic [W_IN-1:0]         eng_a,
    output logic [W_IN-1:0]         eng_b,
    output logic                    eng_st,
    input  logic                    eng_ok,
    input  logic [W_OUT-1:0]        eng_q
);

    if (ID_W != $clog2(N_REQ) || N_REQ < 2 || TMO < 2) begin : g_bad_cfg
        $error("mod_arbiter: need ID_W == clog2(N_REQ), N_REQ >= 2, TMO >= 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    cur_id_q, cur_id_d;
    logic [W_IN-1:0]    eng_a_q, eng_a_d;
    logic [W_IN-1:0]    eng_b_q, eng_b_d;
    logic [W_OUT-1:0]   q_out_q, q_out_d;
    logic [ID_W-1:0]    done_id_q, done_id_d;

    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic [W_IN-1:0]    win_a;
    logic [W_IN-1:0]    win_b;
    logic [ID_W-1:0]    ptr_next;

    // Scan ptr, ptr+1, ... with wrap so the requester after the last one served has priority.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            logic [ID_W-1:0] idx;
            idx = ID_W'((int'(ptr_q) + k) % N_REQ);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                win_a = a_bus[i*W_IN +: W_IN];
                win_b = b_bus[i*W_IN +: W_IN];
            end
        end
    end

    assign ptr_next = (cur_id_q == ID_W'(N_REQ - 1)) ? '0 : cur_id_q + 1'b1;

`ifdef MOD_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO);

    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cur_id_d  = cur_id_q;
        eng_a_d   = eng_a_q;
        eng_b_d   = eng_b_q;
        q_out_d   = q_out_q;
        done_id_d = done_id_q;
`ifdef MOD_ARB_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    eng_a_d  = win_a;
                    eng_b_d  = win_b;
                    cur_id_d = win_id;
                    state_d  = START;
                end
            end
            START: begin
`ifdef MOD_ARB_TIMEOUT_EN
                // Down-counter: terminal count 0 marks the TMO-th WAIT cycle.
                tmo_cnt_d = TMO_W'(TMO - 1);
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (eng_ok) begin
                    q_out_d   = eng_q;
                    done_id_d = cur_id_q;
                    ptr_d     = ptr_next;
                    state_d   = RESP;
                end
`ifdef MOD_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == '0) begin
                    q_out_d   = '1;
                    done_id_d = cur_id_q;
                    ptr_d     = ptr_next;
                    err_d     = 1'b1;
                    state_d   = RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cur_id_q  <= '0;
            eng_a_q   <= '0;
            eng_b_q   <= '0;
            q_out_q   <= '0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cur_id_q  <= cur_id_d;
            eng_a_q   <= eng_a_d;
            eng_b_q   <= eng_b_d;
            q_out_q   <= q_out_d;
            done_id_q <= done_id_d;
        end
    end

`ifdef MOD_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        gnt     = '0;
        eng_st  = 1'b0;
        done    = 1'b0;
        busy    = (state_q != IDLE);
        eng_a   = eng_a_q;
        eng_b   = eng_b_q;
        q_out   = q_out_q;
        done_id = done_id_q;
        if (state_q == START) begin
            gnt    = N_REQ'(1) << cur_id_q;
            eng_st = 1'b1;
        end
        if (state_q == RESP) begin
            done = 1'b1;
        end
    end

endmodule
